// File: rtl/whack_pkg.sv
// whack_pkg: shared state type and constants for the whack-a-mole judge
package whack_pkg;
  typedef enum logic [1:0] {SPAWN, UP, COOL, OVER} state_t;
  localparam int NUM_MOLES = 4;
  localparam int UP_TICKS = 2;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/lfsr8.sv
// lfsr8: free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1
module lfsr8 import whack_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);
  always_ff @(posedge clk)
    q <= reset ? LFSR_SEED : {q[6:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/mole_judge.sv
// mole_judge: whack-a-mole game judge; define MISS_PENALTY_EN to penalise wrong-hole presses
module mole_judge import whack_pkg::*; (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [NUM_MOLES-1:0] btn,
  input  logic [4:0]           time_left,
  output logic [NUM_MOLES-1:0] mole,
  output logic                 score,
  output logic [7:0]           hits,
  output logic                 game_over
);
`ifdef MISS_PENALTY_EN
  localparam logic PEN = 1'b1;
`else
  localparam logic PEN = 1'b0;
`endif
  state_t state, state_n;
  logic [7:0] lfsr, hits_r;
  logic [NUM_MOLES-1:0] btn_q, rise, lit;
  logic [1:0] hole, pick, cnt;
  logic score_r, live, hit, miss, unused_lfsr;
  lfsr8 u_lfsr (.clk, .reset, .q(lfsr));
  assign unused_lfsr = ^lfsr[7:2];
  assign live = time_left != '0;
  assign rise = btn & ~btn_q;
  assign lit = NUM_MOLES'(1) << hole;
  assign pick = (lfsr[1:0] == hole) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
  assign hit = live && state == UP && |(rise & lit);
  assign miss = live && state == UP && !hit && |(rise & ~lit);
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SPAWN;
      btn_q   <= '0;
      hole    <= '0;
      cnt     <= '0;
      score_r <= 1'b0;
      hits_r  <= '0;
    end else begin
      state   <= state_n;
      btn_q   <= btn;
      hole    <= (state == SPAWN) ? pick : hole;
      cnt     <= (state == UP) ? cnt + 2'(tick) : '0;
      // score spans exactly one tick edge so the timer counts it once
      score_r <= (!live || state == OVER) ? 1'b0 : hit ? 1'b1 : tick ? 1'b0 : score_r;
      if (hit && hits_r != 8'hFF)
        hits_r <= hits_r + 8'd1;
      else if (PEN && miss && hits_r != 8'h00)
        hits_r <= hits_r - 8'd1;
    end
  end
  always_comb begin
    state_n = state;
    if (state == OVER || !live)
      state_n = OVER;
    else if (state == SPAWN)
      state_n = UP;
    else if (state == UP)
      state_n = (hit || (PEN && miss) || (tick && cnt == 2'(UP_TICKS - 1))) ? COOL : UP;
    else
      state_n = tick ? SPAWN : COOL;
  end
  always_comb begin
    mole      = (state == UP) ? lit : '0;
    score     = score_r;
    hits      = hits_r;
    game_over = state == OVER;
  end
endmodule

// File: tb/tb_mole_judge.sv
// tb_mole_judge: vector table, directed corner sequences and a random run against a game-rule model
module tb_mole_judge;
`ifdef MISS_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
  logic [3:0] btn = '0, mole;
  logic [4:0] time_left = 5'd20;
  logic score, game_over;
  logic [7:0] hits;
  int errors = 0, checks = 0;

  mole_judge dut (.clk(clk), .reset(reset), .tick(tick), .btn(btn), .time_left(time_left),
                  .mole(mole), .score(score), .hits(hits), .game_over(game_over));

  always #5 clk = ~clk;

  // game model: hole number lit (-1 none) plus phase flags
  int m_lit, m_prev, m_ticks, m_hits;
  bit m_spawn, m_cool, m_over, m_score;
  logic [7:0] m_lfsr;
  logic [3:0] m_btnq;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    int taps[4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    foreach (taps[k]) fb ^= q[taps[k] - 1];
    return {q[6:0], fb};
  endfunction

  task automatic model_step();
    logic [3:0] e;
    int h;
    if (reset) begin
      m_lit = -1; m_prev = 0; m_ticks = 0; m_hits = 0;
      m_spawn = 1; m_cool = 0; m_over = 0; m_score = 0;
      m_lfsr = 8'hA5; m_btnq = '0;
      return;
    end
    e = btn & ~m_btnq;
    m_btnq = btn;
    if (m_over) begin
    end else if (time_left == 0) begin
      m_over = 1; m_lit = -1; m_score = 0;
    end else begin
      if (tick) m_score = 0;
      if (m_spawn) begin
        h = m_lfsr % 4;
        if (h == m_prev) h = (h + 1) % 4;
        m_prev = h; m_lit = h; m_spawn = 0; m_ticks = 0;
      end else if (m_lit >= 0) begin
        if (e[m_lit]) begin
          m_hits = (m_hits < 255) ? m_hits + 1 : 255;
          m_score = 1; m_lit = -1; m_cool = 1;
        end else if (PEN && (e & ~(4'b1 << m_lit)) != 0) begin
          m_hits = (m_hits > 0) ? m_hits - 1 : 0;
          m_lit = -1; m_cool = 1;
        end else if (tick) begin
          m_ticks++;
          if (m_ticks == 2) begin m_lit = -1; m_cool = 1; end
        end
      end else if (m_cool && tick) begin
        m_cool = 0; m_spawn = 1;
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] b, input logic t, input logic [4:0] tl);
    @(negedge clk);
    reset = r; btn = b; tick = t; time_left = tl;
    @(posedge clk);
    model_step();
    #1;
    chk("model_mole", int'(mole), m_lit < 0 ? 0 : (1 << m_lit));
    chk("model_score", int'(score), int'(m_score));
    chk("model_hits", int'(hits), m_hits);
    chk("model_over", int'(game_over), int'(m_over));
  endtask

  typedef struct {
    logic [3:0] btn; logic tick; logic [3:0] mole; logic score; logic [7:0] hits;
  } vec_t;
  vec_t tv[12];

  function automatic vec_t mk(logic [3:0] b, logic t, logic [3:0] m, logic s, logic [7:0] h);
    vec_t v;
    v.btn = b; v.tick = t; v.mole = m; v.score = s; v.hits = h;
    return v;
  endfunction

  initial begin
    tv[0]  = mk(4'b0000, 0, 4'b0010, 0, 0);
    tv[1]  = mk(4'b0010, 0, 4'b0000, 1, 1);
    tv[2]  = mk(4'b0010, 0, 4'b0000, 1, 1);
    tv[3]  = mk(4'b0000, 1, 4'b0000, 0, 1);
    tv[4]  = mk(4'b0000, 0, 4'b0001, 0, 1);
    tv[5]  = mk(4'b0000, 1, 4'b0001, 0, 1);
    tv[6]  = mk(4'b0000, 1, 4'b0000, 0, 1);
    tv[7]  = mk(4'b0000, 0, 4'b0000, 0, 1);
    tv[8]  = mk(4'b0000, 1, 4'b0000, 0, 1);
    tv[9]  = mk(4'b0000, 0, 4'b0010, 0, 1);
    tv[10] = mk(4'b1000, 0, PEN ? 4'b0000 : 4'b0010, 0, PEN ? 8'd0 : 8'd1);
    tv[11] = mk(4'b1000, 0, PEN ? 4'b0000 : 4'b0010, 0, PEN ? 8'd0 : 8'd1);

    cyc(1, 0, 0, 20);
    cyc(1, 0, 0, 20);
    chk("reset_mole", int'(mole), 0);
    chk("reset_score", int'(score), 0);
    chk("reset_hits", int'(hits), 0);
    chk("reset_over", int'(game_over), 0);
    foreach (tv[i]) begin
      cyc(0, tv[i].btn, tv[i].tick, 20);
      chk($sformatf("vec%0d_mole", i), int'(mole), int'(tv[i].mole));
      chk($sformatf("vec%0d_score", i), int'(score), int'(tv[i].score));
      chk($sformatf("vec%0d_hits", i), int'(hits), int'(tv[i].hits));
      chk($sformatf("vec%0d_over", i), int'(game_over), 0);
    end

    // ten idle cycles from reset leave exactly one mole lit
    cyc(1, 0, 0, 20);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 20);
    chk("idle_onehot", int'($countones(mole)), 1);
    chk("idle_hits", int'(hits), 0);

    // wrong hole with zero hits
    cyc(1, 0, 0, 20);
    cyc(0, 0, 0, 20);
    cyc(0, 4'b0001, 0, 20);
    chk("wrong_mole", int'(mole), PEN ? 0 : 2);
    chk("wrong_hits", int'(hits), 0);

    // button held through reset release is not an edge
    cyc(1, 4'b0010, 0, 20);
    cyc(0, 4'b0010, 0, 20);
    cyc(0, 4'b0010, 0, 20);
    chk("held_mole", int'(mole), 2);
    chk("held_hits", int'(hits), 0);

    // hit on the same edge as time running out
    cyc(1, 0, 0, 20);
    cyc(0, 0, 0, 20);
    cyc(0, 4'b0010, 0, 0);
    chk("over_flag", int'(game_over), 1);
    chk("over_hits", int'(hits), 0);
    chk("over_score", int'(score), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 20);
      cyc(0, 4'b1111, 0, 20);
      chk("over_hold_mole", int'(mole), 0);
      chk("over_hold_flag", int'(game_over), 1);
    end

    // saturate at 255
    cyc(1, 0, 0, 20);
    cyc(0, 0, 0, 20);
    for (int i = 0; i < 256; i++) begin
      if (mole == 0) begin
        chk("sat_mole_lit", int'(mole), 1);
        break;
      end
      if (i == 255) chk("sat_before", int'(hits), 255);
      cyc(0, mole, 0, 20);
      if (i == 255) begin
        chk("sat_hits", int'(hits), 255);
        chk("sat_score", int'(score), 1);
      end
      cyc(0, 0, 1, 20);
      cyc(0, 0, 0, 20);
    end

    // random play
    cyc(1, 0, 0, 20);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] b;
      logic [4:0] tl;
      b = ($urandom_range(0, 2) == 0) ? mole : ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      tl = ($urandom_range(0, 299) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cyc($urandom_range(0, 149) == 0, b, $urandom_range(0, 2) == 0, tl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
